// File: rtl/de_pkg.sv
// ============================================================================
// Module : de_pkg
// Brief  : Shared control-bundle layout for the decode-to-execute stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package de_pkg;

    localparam int DE_CTRL_W   = 16;

    localparam int REG_WRITE   = 0;
    localparam int ALU_SRC     = 1;
    localparam int MEM_WRITE   = 2;
    localparam int RESULT_SRC_LO = 3;
    localparam int RESULT_SRC_HI = 4;
    localparam int JUMP        = 5;
    localparam int BRANCH_LO   = 6;
    localparam int BRANCH_HI   = 8;
    localparam int ALU_CTRL_LO = 9;
    localparam int ALU_CTRL_HI = 12;
    localparam int ALU_SRC_A   = 13;
    localparam int PC_TGT_SRC  = 14;

    // Bit 15 is reserved and must stay zero.
    typedef struct packed {
        logic       rsvd;
        logic       pc_tgt_src;
        logic       alu_src_a;
        logic [3:0] alu_ctrl;
        logic [2:0] branch;
        logic       jump;
        logic [1:0] result_src;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } de_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/de_pipe_stage_if.sv
// ============================================================================
// Module : de_pipe_stage_if
// Brief  : Decode-side and execute-side handshake/payload bundle of the stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface de_pipe_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int RAW    = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl_d;
    logic [XLEN-1:0]   rd1_d;
    logic [XLEN-1:0]   rd2_d;
    logic [XLEN-1:0]   imm_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   pcplus4_d;
    logic [RAW-1:0]    rs1_d;
    logic [RAW-1:0]    rs2_d;
    logic [RAW-1:0]    rd_d;
    logic              fwd_a;
    logic              fwd_b;
    logic [XLEN-1:0]   result_w;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl_e;
    logic [XLEN-1:0]   rd1_e;
    logic [XLEN-1:0]   rd2_e;
    logic [XLEN-1:0]   imm_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   pcplus4_e;
    logic [RAW-1:0]    rs1_e;
    logic [RAW-1:0]    rs2_e;
    logic [RAW-1:0]    rd_e;

    // Driven by decode/hazard/execute environment.
    modport master (
        output in_valid, ctrl_d, rd1_d, rd2_d, imm_d, pc_d, pcplus4_d,
               rs1_d, rs2_d, rd_d, fwd_a, fwd_b, result_w, flush, out_ready,
        input  in_ready, out_valid, ctrl_e, rd1_e, rd2_e, imm_e, pc_e,
               pcplus4_e, rs1_e, rs2_e, rd_e
    );

    // The pipeline stage itself.
    modport slave (
        input  in_valid, ctrl_d, rd1_d, rd2_d, imm_d, pc_d, pcplus4_d,
               rs1_d, rs2_d, rd_d, fwd_a, fwd_b, result_w, flush, out_ready,
        output in_ready, out_valid, ctrl_e, rd1_e, rd2_e, imm_e, pc_e,
               pcplus4_e, rs1_e, rs2_e, rd_e
    );

endinterface

`default_nettype wire

// File: rtl/de_entry_reg.sv
// ============================================================================
// Module : de_entry_reg
// Brief  : One payload+valid storage entry with load enable and sync clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module de_entry_reg
    import de_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         i_clr,
    input  wire logic         i_load,
    input  wire logic         i_valid_we,
    input  wire logic         i_valid_d,
    input  wire logic [W-1:0] i_data,
    output logic              o_valid,
    output logic [W-1:0]      o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clear (flush) dominates any valid update issued in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_valid_we) begin
            r_valid <= i_valid_d;
        end
    end

    // Payload only moves on a real load so stalls do not toggle the datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/de_pipe_stage.sv
// ============================================================================
// Module : de_pipe_stage
// Brief  : Decode-to-execute stage with valid/ready, optional skid, flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module de_pipe_stage
    import de_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int RAW    = 5,
    parameter int SKID   = 1
) (
    input  wire logic   clock,
    input  wire logic   reset,
    de_pipe_stage_if.slave bus
);

    localparam int PL_W = CTRL_W + 5 * XLEN + 3 * RAW;

    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic [PL_W-1:0]   w_in_pl;
    logic              w_in_ready;
    logic              w_acc_in;
    logic              w_m_free;
    logic              w_m_load;
    logic [PL_W-1:0]   w_m_d;
    logic              w_m_v;
    logic [PL_W-1:0]   w_m_pl;
    logic              w_s_v;
    logic [PL_W-1:0]   w_s_pl;
    logic [CTRL_W-1:0] w_m_ctrl;

    // Forwarding is resolved once, at acceptance; stored operands never re-forward.
    assign w_op1   = bus.fwd_a ? bus.result_w : bus.rd1_d;
    assign w_op2   = bus.fwd_b ? bus.result_w : bus.rd2_d;
    assign w_in_pl = {bus.ctrl_d, w_op1, w_op2, bus.imm_d, bus.pc_d,
                      bus.pcplus4_d, bus.rs1_d, bus.rs2_d, bus.rd_d};

    assign w_acc_in = bus.in_valid & w_in_ready;
    assign w_m_free = ~w_m_v | bus.out_ready;
    assign w_m_load = ~bus.flush & w_m_free & (w_s_v | w_acc_in);
    assign w_m_d    = w_s_v ? w_s_pl : w_in_pl;

    de_entry_reg #(.W(PL_W)) u_main (
        .clock      (clock),
        .reset      (reset),
        .i_clr      (bus.flush),
        .i_load     (w_m_load),
        .i_valid_we (w_m_free),
        .i_valid_d  (w_s_v | w_acc_in),
        .i_data     (w_m_d),
        .o_valid    (w_m_v),
        .o_data     (w_m_pl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic w_s_load;

            // Skid catches the word that arrives while M is stalled.
            assign w_s_load   = ~bus.flush & w_m_v & ~bus.out_ready & w_acc_in;
            assign w_in_ready = ~w_s_v;

            de_entry_reg #(.W(PL_W)) u_skid (
                .clock      (clock),
                .reset      (reset),
                .i_clr      (bus.flush),
                .i_load     (w_s_load),
                .i_valid_we (w_s_load | (w_m_free & w_s_v)),
                .i_valid_d  (w_s_load),
                .i_data     (w_in_pl),
                .o_valid    (w_s_v),
                .o_data     (w_s_pl)
            );
        end else begin : g_no_skid
            assign w_s_v      = 1'b0;
            assign w_s_pl     = '0;
            assign w_in_ready = w_m_free;
        end
    endgenerate

    assign {w_m_ctrl, bus.rd1_e, bus.rd2_e, bus.imm_e, bus.pc_e, bus.pcplus4_e,
            bus.rs1_e, bus.rs2_e, bus.rd_e} = w_m_pl;

    // Bubbles must never carry RegWrite/MemWrite/Jump/Branch into execute.
    assign bus.ctrl_e    = w_m_v ? w_m_ctrl : '0;
    assign bus.out_valid = w_m_v;
    assign bus.in_ready  = w_in_ready;

endmodule

`default_nettype wire

// File: doc/de_pipe_stage.md
Name: de_pipe_stage

Overview:
Parametrised decode-to-execute pipeline stage for the RISC-V core, replacing the fixed D->E register bank.
- Captures the packed control bundle, operands, immediate, PC values and register indices.
- Adds a valid/ready handshake with a 1-entry skid buffer, a synchronous flush for branch/jump redirect, and bubble gating of control outputs.
- Sits between the decoder/register file and the execute stage; the hazard unit drives out_ready (stall) and flush.

Parameters:
XLEN, 32, datapath width of operands, immediate and PC
CTRL_W, 16, width of packed control bundle
RAW, 5, register-index width
SKID, 1, 1 = 1-entry skid buffer with registered in_ready; 0 = no skid, combinational in_ready

Ports:
clock  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decode holds a valid instruction
in_ready  output  1  stage accepts this cycle
ctrl_d  input  CTRL_W  packed control bundle from decoder
rd1_d  input  XLEN  register-file read port 1
rd2_d  input  XLEN  register-file read port 2
imm_d  input  XLEN  extended immediate
pc_d  input  XLEN  instruction PC
pcplus4_d  input  XLEN  PC+4
rs1_d  input  RAW  source index 1
rs2_d  input  RAW  source index 2
rd_d  input  RAW  destination index
fwd_a  input  1  select result_w for operand 1
fwd_b  input  1  select result_w for operand 2
result_w  input  XLEN  writeback result
flush  input  1  kill all held and incoming instructions
out_valid  output  1  execute-side instruction valid
out_ready  input  1  execute consumes this cycle
ctrl_e  output  CTRL_W  control bundle; zero when out_valid=0
rd1_e, rd2_e, imm_e, pc_e, pcplus4_e  output  XLEN  registered payload
rs1_e, rs2_e, rd_e  output  RAW  registered indices

Behaviour:
- Reset: clock is clock; reset is reset, asynchronous, active-high.
  - All storage clears to 0: m_v, s_v, ctrl, payload, indices.
  - After reset: out_valid=0, ctrl_e=0, all payload outputs 0, in_ready=1.
- Storage: main entry M with valid m_v; skid entry S with valid s_v (present only when SKID=1).
- Capture mux, applied at acceptance:
  - operand1 = fwd_a ? result_w : rd1_d.
  - operand2 = fwd_b ? result_w : rd2_d.
  - Once stored, values never re-forward.
- Handshake signals:
  - acc_in = in_valid & in_ready.
  - acc_out = m_v & out_ready.
  - in_ready = ~s_v when SKID=1 (pure flop output, no path from out_ready).
  - in_ready = ~m_v | out_ready when SKID=0.
- Update rules when flush=0, SKID=1:
  - If ~m_v or acc_out, and s_v: M <= S, s_v <= 0, m_v <= 1.
  - If ~m_v or acc_out, and ~s_v: M <= input when acc_in; m_v <= acc_in.
  - If m_v and ~out_ready and acc_in: S <= input, s_v <= 1.
  - Otherwise: hold.
- SKID=0: same rules with S absent.
- Latency: one cycle from acc_in to out_valid when the stage is empty.
- Ordering: strict FIFO order; no reordering, duplication or loss except by flush.
- Flush, synchronous and highest priority:
  - m_v <= 0 and s_v <= 0 next cycle.
  - Any same-cycle input is dropped even when in_ready=1.
  - A same-cycle acc_out still counts as consumed.
- Bubble gating:
  - ctrl_e = m_v ? ctrl_reg : 0, so RegWrite, MemWrite, Jump and Branch are never asserted for a bubble.
  - Payload outputs are not gated; they hold the last loaded value.
- Payload registers load only on an M/S load; they hold otherwise, which avoids toggling during stalls.
- Full condition: s_v=1 gives in_ready=0; decode must hold its inputs.
- Reset asserted mid-stall: both entries are discarded immediately (asynchronous clear).

Decomposition:
- Shared package de_pkg holds:
  - the ctrl bundle typedef (CTRL_W=16);
  - bit-position constants: REG_WRITE=0, ALU_SRC=1, MEM_WRITE=2, RESULT_SRC=4:3, JUMP=5, BRANCH=8:6, ALU_CTRL=12:9, ALU_SRC_A=13, PC_TGT_SRC=14, bit 15 reserved 0.
- One natural sub-module, de_entry_reg: a single payload+valid register with load enable and clear, instantiated for M and S.

Test Plan:
- Reset then single push: in_valid=1, ctrl_d=16'h0001, rd1_d=32'h11, rd_d=5 -> next cycle out_valid=1, ctrl_e=16'h0001, rd1_e=32'h11, rd_e=5; before that ctrl_e=0.
- Forwarding: fwd_a=1, result_w=32'hDEAD, rd1_d=32'h1 -> rd1_e=32'hDEAD; a later change of result_w during a stall leaves rd1_e unchanged.
- Stall and skid (SKID=1): out_ready=0, push A=32'hA then B=32'hB -> in_ready=0 after B; release out_ready -> outputs A then B on consecutive cycles; no loss.
- Flush with both entries full: flush=1 with in_valid=1 and C=32'hC -> next cycle out_valid=0, ctrl_e=0, in_ready=1; C never appears.
- Back-to-back throughput: out_ready=1, push 8 instructions 0..7 on consecutive cycles -> out_valid stays high 8 cycles; output sequence 0..7.
- SKID=0 build: out_ready=0 with M full -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> accept and drain in the same cycle.
